// File: rtl/reg_file_param.sv
// reg_file_param: parametrised multi-read-port register file with byte-enable
// writes, optional hardwired-zero R0 and a post-reset hardware clear sequencer.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
module reg_file_param #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NREG    = 32,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W/8-1:0]     wr_be,
  input  logic [DATA_W-1:0]       wr_data,
  output logic                    ready,
  output logic                    wr_drop
);

  localparam int NBYTE = DATA_W / 8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic              last_clr;
  logic              wr_ok;
  logic              drop_nxt;
  logic [DATA_W-1:0] mem [NREG];

  // An address is live if it maps to a real register that is not the hardwired zero.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return (int'(a) < NREG) && !((ZERO_R0 != 0) && (a == '0));
  endfunction

  // Byte-wise merge: new bytes where the enable is set, old bytes elsewhere.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [NBYTE-1:0]  be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < NBYTE; b++) begin
      if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

  assign last_clr = (int'(clr_ptr) == NREG - 1);
  assign wr_ok    = wr_en && (state == READY) && addr_live(wr_addr);
  assign drop_nxt = wr_en && ((state == CLEAR) || !addr_live(wr_addr));

  // Next-state logic: sweep through every register once, then serve accesses.
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (last_clr) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  // Control registers: state, clear pointer, ready flag and drop pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready   <= (state_nxt == READY);
      wr_drop <= drop_nxt;
      if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
    end
  end

  // Array update: clear sweep has priority; normal writes only once ready.
  always_ff @(posedge clk) begin
    if (!rst && (state == CLEAR)) begin
      mem[clr_ptr] <= '0;
    end else if (wr_ok) begin
      for (int b = 0; b < NBYTE; b++) begin
        if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Combinational read ports; zero while clearing or for dead addresses.
  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] word;
    rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      a    = rd_addr[k*ADDR_W +: ADDR_W];
      word = '0;
      if ((state == READY) && addr_live(a)) word = mem[a];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (a == wr_addr)) word = merge_bytes(word, wr_data, wr_be);
`endif
      rd_data[k*DATA_W +: DATA_W] = word;
    end
  end

`ifndef REGFILE_BYPASS_EN
  // Without forwarding the merge helper is only referenced here to keep it elaborated.
  logic [DATA_W-1:0] unused_merge;
  assign unused_merge = merge_bytes('0, '0, '0);
`endif

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default 32-register instance plus a
// 24-register instance sharing the same inputs for out-of-range checks.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data24;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        ready, ready24;
  logic        wr_drop, wr_drop24;

  int tests = 0;
  int fails = 0;
  int cnt;
  logic [31:0] exp_byp;
  logic        saw_drop;

  always #5 clk = ~clk;

  reg_file_param dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .ready(ready), .wr_drop(wr_drop)
  );

  reg_file_param #(.NREG(24)) dut24 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data24),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .ready(ready24), .wr_drop(wr_drop24)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    repeat (3) step();
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_drop", 64'(wr_drop), 64'd0);
    check("rst_rd_forced0", rd_data, 64'd0);

    // Clear sequence timing
    rst = 1'b0; cnt = 0; saw_drop = 1'b0;
    while (!ready && cnt < 100) begin
      step(); cnt++;
      if (wr_drop) saw_drop = 1'b1;
    end
    check("clear_cycles", 64'(cnt), 64'd32);
    check("clear_no_drop", 64'(saw_drop), 64'd0);
    check("ready24", 64'(ready24), 64'd1);
    for (int i = 0; i < 32; i++) begin
      set_rd(5'(i), 5'(31 - i));
      check($sformatf("clear_r%0d", i), rd_data, 64'd0);
    end

    // Byte-enable writes to r5
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hAABBCCDD; wr_be = 4'hF;
    step();
    wr_data = 32'h11223344; wr_be = 4'b0101;
    step();
    wr_en = 1'b0;
    check("be_no_drop", 64'(wr_drop), 64'd0);
    set_rd(5'd5, 5'd5);
    check("be_r5_both", rd_data, {32'hAA22CC44, 32'hAA22CC44});
    check("be_r5_dut24", rd_data24, {32'hAA22CC44, 32'hAA22CC44});

    // Zero-be write is a no-op and not a drop
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0; wr_be = 4'h0;
    step();
    wr_en = 1'b0;
    check("be0_no_drop", 64'(wr_drop), 64'd0);
    check("be0_r5_hold", rd_data[31:0], 64'hAA22CC44);

    // Write to hardwired-zero r0
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    step();
    wr_en = 1'b0;
    check("r0_drop", 64'(wr_drop), 64'd1);
    set_rd(5'd0, 5'd0);
    check("r0_reads0", rd_data, 64'd0);
    step();
    check("r0_drop_pulse", 64'(wr_drop), 64'd0);

    // Out-of-range write on the 24-register instance
    wr_en = 1'b1; wr_addr = 5'd30; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
    step();
    wr_en = 1'b0;
    check("oor_drop24", 64'(wr_drop24), 64'd1);
    check("oor_drop32", 64'(wr_drop), 64'd0);
    set_rd(5'd30, 5'd5);
    check("oor_r30_24", rd_data24, {32'hAA22CC44, 32'h0});
    check("r30_32", rd_data[31:0], 64'hDEADBEEF);
    set_rd(5'd6, 5'd23);
    check("oor_untouched24", rd_data24, 64'd0);

    // Same-cycle write/read on r7
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h00000001; wr_be = 4'hF;
    step();
    wr_data = 32'hCAFEF00D; wr_be = 4'b0011;
    set_rd(5'd7, 5'd7);
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'h0000F00D;
`else
    exp_byp = 32'h00000001;
`endif
    check("byp_same_cycle", rd_data, {exp_byp, exp_byp});
    step();
    wr_en = 1'b0;
    #1;
    check("byp_next_cycle", rd_data, {32'h0000F00D, 32'h0000F00D});

    // Write during clear is dropped; outputs forced to 0 while clearing
    rst = 1'b1;
    step();
    check("rst2_ready", 64'(ready), 64'd0);
    rst = 1'b0; cnt = 0;
    step(); cnt++;
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h12345678; wr_be = 4'hF;
    step(); cnt++;
    wr_en = 1'b0;
    check("clear_wr_drop", 64'(wr_drop), 64'd1);
    set_rd(5'd30, 5'd7);
    check("clear_forced0", rd_data, 64'd0);
    while (!ready && cnt < 100) begin
      step(); cnt++;
    end
    check("clear2_cycles", 64'(cnt), 64'd32);
    set_rd(5'd31, 5'd30);
    check("r31_after_clear", rd_data, 64'd0);

    // Reset in the middle of clear restarts the sweep
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    check("mid_ready_low", 64'(ready), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0; cnt = 0;
    while (!ready && cnt < 100) begin
      step(); cnt++;
    end
    check("restart_cycles", 64'(cnt), 64'd32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
